uart_cmd_rx: RTL and testbench
==============================

Name: uart_cmd_rx

Overview:
- Serial command receiver: 8N1 UART, LSB first, line idle high.
- Recovers ASCII command bytes from the board Rx pin and presents them as a held 8-bit Cmd bus plus a one-cycle CmdValid strobe.
- Sits directly upstream of the LED toggle state machines; they compare Cmd continuously, e.g. 'r'=0x72 turns the red LED off, 'R'=0x52 turns it on.

Parameters:
- CLKS_PER_BIT, 434, Clock cycles per UART bit (50 MHz / 115200). Legal range is 4 or more.
- HALF_BIT, CLKS_PER_BIT/2 (floor), cycles from the synchronized start edge to mid-start sample. Derived; not overridden.

Ports:
- Clock     in   1  system clock
- Reset     in   1  synchronous, active-high
- Rx        in   1  asynchronous serial line from the pin
- Cmd       out  8  last correctly framed byte; held until the next good byte
- CmdValid  out  1  one-cycle pulse, high in the cycle Cmd takes a new value
- FrameErr  out  1  one-cycle pulse on a bad stop bit
- Busy      out  1  high whenever state is not IDLE

Behaviour:
- Reset is synchronous, active-high, on Clock. The interface names are Reset and Clock.
- Reset values:
  - Cmd=0x00, CmdValid=0, FrameErr=0, Busy=0.
  - State=IDLE, counters=0, shift register=0.
  - Both synchronizer flops reset to 1 (idle line).
- Rx passes through a 2-flop synchronizer; rxs is the synchronized value. All decisions use rxs only.
- One counter (width clog2(CLKS_PER_BIT)) and one 3-bit bit index.
- State machine: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on a cycle with rxs==0, go to START with counter=0.
  - START:
    - Counter increments until it reaches HALF_BIT-1, then rxs is sampled.
    - rxs==0: go to DATA, counter=0, index=0.
    - rxs==1: glitch; return to IDLE with no output pulse.
  - DATA:
    - Counter runs 0..CLKS_PER_BIT-1.
    - At CLKS_PER_BIT-1, shift rxs into the MSB of the shift register (right shift, so LSB-first data lands correctly) and reset the counter.
    - After index 7 is sampled, go to STOP; otherwise index+1.
  - STOP:
    - Counter runs 0..CLKS_PER_BIT-1; sample rxs at the end.
    - rxs==1: Cmd <= shift register, CmdValid=1 for the next cycle only, go to IDLE.
    - rxs==0: FrameErr=1 for the next cycle only, Cmd unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs==1, then go to IDLE. This prevents a break condition from being decoded as bytes.
- Latency: let t0 be the Clock edge where IDLE sees rxs==0. CmdValid is high in cycle t0+HALF_BIT+9*CLKS_PER_BIT+1. Rx pin to rxs adds 2 cycles.
- Back-to-back frames: after a good stop, IDLE is re-entered at mid-stop-bit, so the next start edge, even with zero inter-frame gap, is caught.
- CmdValid and FrameErr are never high in the same cycle. Each is registered; no combinational path from Rx.
- Reset mid-frame: the frame is abandoned, all outputs return to reset values, and the next complete frame is received normally.
- A Cmd of 0x00 is never mistaken for a command downstream, because the consumers only match printable codes.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, WAIT_HIGH),
  - the default CLKS_PER_BIT for 50 MHz/115200,
  - ASCII command constants CMD_R_OFF=8'h72 and CMD_R_ON=8'h52, also used by the LED FSMs.
- Sub-module sync_2ff: 1-bit two-flop synchronizer with Reset value parameter. It is reused for the button inputs.

Test Plan (CLKS_PER_BIT=16, HALF_BIT=8):
- Send 0x72 with a clean 8N1 frame -> exactly one CmdValid pulse, Cmd=0x72 afterwards, FrameErr stays 0, Busy low after mid-stop.
- Drive Rx low for 4 cycles, then high -> START aborts at the mid-bit sample. No CmdValid, no FrameErr; Cmd keeps its prior value; back in IDLE.
- Send 0x52 followed immediately (no gap) by 0x72 -> two CmdValid pulses 160 cycles apart; Cmd=0x52 then 0x72.
- Send 0x41 with the stop bit forced 0, and hold Rx low 40 more cycles -> one FrameErr pulse; Cmd unchanged; no activity until Rx returns high. A following 0x52 is then received correctly.
- Assert Reset for 1 cycle during data bit 4 of 0x72 -> Cmd=0x00, CmdValid=0, Busy=0 next cycle. A subsequent full 0x52 frame yields Cmd=0x52 with one CmdValid.
- Latency check: measure from the IDLE rxs==0 edge to CmdValid -> exactly 8+144+1=153 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit timing and the
// ASCII command codes matched by the LED state machines.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_e;

  // 50 MHz system clock at 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  localparam logic [7:0] CMD_R_OFF = 8'h72;
  localparam logic [7:0] CMD_R_ON  = 8'h52;

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Serial line in, framed command byte and status strobes out.
interface uart_cmd_rx_if;
  logic       Rx;
  logic [7:0] Cmd;
  logic       CmdValid;
  logic       FrameErr;
  logic       Busy;

  modport master (input Rx, output Cmd, output CmdValid, output FrameErr, output Busy);
  modport slave  (output Rx, input Cmd, input CmdValid, input FrameErr, input Busy);
endinterface

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous pins; reset value selects the
// level the line is assumed to rest at.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic Clock,
  input  logic Reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART command receiver: samples each bit at its centre, presents a held
// command byte with a one-cycle valid strobe, and flags bad stop bits.
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic          Clock,
  input  logic          Reset,
  uart_cmd_rx_if.master bus
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             w_rxs;
  uart_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [7:0]       r_cmd;
  logic             r_cmd_valid;
  logic             r_frame_err;
  logic             w_load;
  logic             w_ferr;

  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .Clock (Clock),
    .Reset (Reset),
    .i_d   (bus.Rx),
    .o_q   (w_rxs)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_cmd_valid <= w_load;
      r_frame_err <= w_ferr;
      if (w_load) r_cmd <= r_shift;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rxs) begin
          w_state_nxt = START;
          w_cnt_nxt   = '0;
        end
      end
      // A start bit that is high again at its centre was a glitch
      START: begin
        if (r_cnt == CNT_HALF_LAST) begin
          w_cnt_nxt = '0;
          if (!w_rxs) begin
            w_state_nxt = DATA;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      DATA: begin
        if (r_cnt == CNT_BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rxs, r_shift[7:1]};
          if (r_idx == 3'd7) w_state_nxt = STOP;
          else               w_idx_nxt   = r_idx + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      // Leaving at mid-stop lets a zero-gap next start edge be caught
      STOP: begin
        if (r_cnt == CNT_BIT_LAST) begin
          w_cnt_nxt = '0;
          if (w_rxs) begin
            w_load      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (w_rxs) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.Cmd      = r_cmd;
    bus.CmdValid = r_cmd_valid;
    bus.FrameErr = r_frame_err;
    bus.Busy     = (r_state != IDLE);
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: frames are generated from byte values and
// expected events queued at issue; a monitor consumes them on each strobe.
module tb_uart_cmd_rx;

  localparam int CPB = 16;
  localparam int EXP_LATENCY = CPB / 2 + 9 * CPB + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_start_cyc = 0;
  logic [7:0] model_cmd = 8'h00;
  exp_t exp_q[$];
  int   valid_cyc_q[$];
  exp_t mon_e;

  uart_cmd_rx_if bus ();

  uart_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation
  always @(negedge Clock) begin
    if (!Reset && (bus.CmdValid || bus.FrameErr)) begin
      checks++;
      if (bus.CmdValid && bus.FrameErr) begin
        failures++;
        $display("FAIL both_strobes actual=cv1_fe1 required=one_only");
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe actual=cv%0b_fe%0b cmd=0x%0h required=none",
                 bus.CmdValid, bus.FrameErr, bus.Cmd);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.CmdValid) valid_cyc_q.push_back(cyc);
        if (mon_e.is_err != bus.FrameErr) begin
          failures++;
          $display("FAIL event_kind actual_frameerr=%0b required_frameerr=%0b",
                   bus.FrameErr, mon_e.is_err);
        end else if (!mon_e.is_err && bus.Cmd !== mon_e.data) begin
          failures++;
          $display("FAIL cmd_value actual=0x%0h required=0x%0h", bus.Cmd, mon_e.data);
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge ending the stop bit
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    exp_t e;
    e.is_err = !stop_ok;
    e.data   = b;
    exp_q.push_back(e);
    if (stop_ok) model_cmd = b;
    last_start_cyc = cyc;
    bus.Rx = 1'b0;
    repeat (CPB) @(negedge Clock);
    for (int i = 0; i < 8; i++) begin
      bus.Rx = b[i];
      repeat (CPB) @(negedge Clock);
    end
    bus.Rx = stop_ok;
    repeat (CPB) @(negedge Clock);
  endtask

  task automatic idle(input int n);
    bus.Rx = 1'b1;
    repeat (n) @(negedge Clock);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] partial;
    int n0;
    int lat;
    int hold;
    bit ok;

    bus.Rx = 1'b1;
    repeat (3) @(negedge Clock);
    chk("reset_cmd", 32'(bus.Cmd), 32'h00);
    chk("reset_cmdvalid", 32'(bus.CmdValid), 32'd0);
    chk("reset_frameerr", 32'(bus.FrameErr), 32'd0);
    chk("reset_busy", 32'(bus.Busy), 32'd0);
    Reset = 1'b0;
    idle(5);

    // Clean frame and latency
    n0 = valid_cyc_q.size();
    send_frame(8'h72, 1'b1);
    idle(2);
    chk("t1_pulses", 32'(valid_cyc_q.size() - n0), 32'd1);
    chk("t1_cmd", 32'(bus.Cmd), 32'h72);
    chk("t1_busy_after", 32'(bus.Busy), 32'd0);
    if (valid_cyc_q.size() > n0) begin
      lat = valid_cyc_q[valid_cyc_q.size() - 1] + 1 - (last_start_cyc + 3);
      chk("latency", 32'(lat), 32'(EXP_LATENCY));
    end

    // Short low glitch
    bus.Rx = 1'b0;
    repeat (4) @(negedge Clock);
    idle(3 * CPB);
    chk("glitch_busy", 32'(bus.Busy), 32'd0);
    chk("glitch_cmd", 32'(bus.Cmd), 32'(model_cmd));

    // Back-to-back frames with no gap
    n0 = valid_cyc_q.size();
    send_frame(8'h52, 1'b1);
    send_frame(8'h72, 1'b1);
    idle(4);
    chk("b2b_pulses", 32'(valid_cyc_q.size() - n0), 32'd2);
    if (valid_cyc_q.size() - n0 == 2)
      chk("b2b_spacing", 32'(valid_cyc_q[n0 + 1] - valid_cyc_q[n0]), 32'(10 * CPB));
    chk("b2b_cmd", 32'(bus.Cmd), 32'h72);

    // Bad stop bit followed by a held break
    send_frame(8'h41, 1'b0);
    repeat (40) @(negedge Clock);
    chk("ferr_busy_hold", 32'(bus.Busy), 32'd1);
    chk("ferr_cmd_kept", 32'(bus.Cmd), 32'(model_cmd));
    idle(4);
    chk("ferr_busy_release", 32'(bus.Busy), 32'd0);
    send_frame(8'h52, 1'b1);
    idle(4);
    chk("ferr_next_cmd", 32'(bus.Cmd), 32'h52);

    // Reset during data bit 4
    partial = 8'h72;
    bus.Rx = 1'b0;
    repeat (CPB) @(negedge Clock);
    for (int i = 0; i < 4; i++) begin
      bus.Rx = partial[i];
      repeat (CPB) @(negedge Clock);
    end
    bus.Rx = partial[4];
    repeat (CPB / 2) @(negedge Clock);
    chk("midframe_busy", 32'(bus.Busy), 32'd1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    model_cmd = 8'h00;
    chk("rst_mid_cmd", 32'(bus.Cmd), 32'h00);
    chk("rst_mid_cmdvalid", 32'(bus.CmdValid), 32'd0);
    chk("rst_mid_busy", 32'(bus.Busy), 32'd0);
    idle(3 * CPB);
    n0 = valid_cyc_q.size();
    send_frame(8'h52, 1'b1);
    idle(4);
    chk("rst_after_pulses", 32'(valid_cyc_q.size() - n0), 32'd1);
    chk("rst_after_cmd", 32'(bus.Cmd), 32'h52);

    // Randomized traffic: random bytes, occasional bad stop, random gaps
    for (int k = 0; k < 16; k++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      send_frame(b, ok);
      if (!ok) begin
        hold = $urandom_range(0, 40);
        repeat (hold) @(negedge Clock);
        idle($urandom_range(2, 20));
      end else begin
        idle($urandom_range(0, 20));
      end
    end
    idle(4);
    chk("random_cmd", 32'(bus.Cmd), 32'(model_cmd));

    idle(3 * CPB);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("final_busy", 32'(bus.Busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
